load_extend_ctrl: RTL and testbench
===================================

LOAD_EXTEND_CTRL -- requirements
Module: load_extend_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 Parameter DATA_WIDTH, default 32, memory word and writeback width; only 32 is supported.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles when LOAD_TIMEOUT_EN is defined.
REQ-004 Ports, in order:
- i_CLK in 1: clock, all state on rising edge.
- i_RST in 1: synchronous, active-high reset.
- i_req_valid in 1: load request valid.
- o_req_ready out 1: controller can accept a request.
- i_req_addr in ADDR_WIDTH: byte address.
- i_req_size in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- i_req_signed in 1: 1 means sign-extend, 0 means zero-extend.
- i_req_rd in 5: destination register.
- o_mem_valid out 1: memory read request.
- i_mem_ready in 1: memory accepts the request.
- o_mem_addr out ADDR_WIDTH: word-aligned address, bits [1:0] = 00.
- i_mem_rvalid in 1: read data valid.
- i_mem_rdata in DATA_WIDTH: read word.
- o_wb_valid out 1: writeback valid.
- i_wb_ready in 1: writeback accepted.
- o_wb_data out DATA_WIDTH: extended load result.
- o_wb_rd out 5: destination register.
- o_misalign out 1: one-cycle misaligned-address pulse.
- o_err out 1: one-cycle timeout pulse.
- o_busy out 1: high whenever state is not IDLE.

Function
REQ-005 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP.
REQ-006 o_req_ready SHALL equal (state==IDLE); a request is accepted when i_req_valid and o_req_ready are both high, and addr, size, signed and rd are registered at that point.
REQ-007 On an aligned accept, the FSM SHALL go IDLE->REQ, and o_mem_valid SHALL be high in the following cycle.
REQ-008 Alignment: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
- On a misaligned accept, no memory access SHALL occur.
- o_misalign SHALL pulse in the cycle after accept.
- The FSM SHALL stay in IDLE.
REQ-009 In REQ, o_mem_valid SHALL stay high, with o_mem_addr stable, until i_mem_ready is high; the FSM SHALL then go REQ->WAIT.
REQ-010 i_mem_rvalid SHALL be sampled only in WAIT and ignored in all other states; on rvalid the FSM SHALL capture the extended data and go WAIT->RESP.
REQ-011 Lane select (little-endian):
- Byte = rdata[8*addr[1:0] +: 8].
- Half = rdata[16*addr[1] +: 16].
- Word = rdata.
REQ-012 Extension: the upper bits SHALL be filled with signed & MSB of the selected lane; a word passes through unchanged.
REQ-013 If rd==0, o_wb_data SHALL be 0.
REQ-014 In RESP, o_wb_valid SHALL be high, with o_wb_data and o_wb_rd stable, until i_wb_ready is high; the FSM SHALL then go to IDLE.
- Minimum latency from accept to o_wb_valid is 3 cycles, with zero-wait memory.
REQ-015 A new request SHALL NOT be accepted in the writeback-handshake cycle; o_req_ready rises in the following cycle.

Reset
REQ-016 While i_RST is high, the following SHALL be 0 at the next edge: state (IDLE), o_mem_valid, o_wb_valid, o_wb_data, o_wb_rd, o_misalign, o_err, o_busy and the timeout counter.
REQ-017 A reset mid-transaction SHALL drop the transaction; a late i_mem_rvalid arriving in IDLE SHALL be ignored.

Configuration
REQ-018 Macro LOAD_TIMEOUT_EN, when defined:
- A counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- When the counter reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE, pulse o_err for one cycle, and produce no writeback.
REQ-019 When LOAD_TIMEOUT_EN is undefined, WAIT SHALL be unbounded, o_err SHALL be tied to 0, and no counter SHALL exist.

Structure
REQ-020 The shared package load_pkg SHALL hold:
- the state encodings;
- the size codes (SZ_BYTE, SZ_HALF, SZ_WORD).
REQ-021 There SHALL be one sub-module, load_lane_ext: combinational lane select plus sign/zero extension, instantiated once.

Verification
REQ-022 Byte, signed: LB with addr 0x1003 and rdata 0x80FF_FF7F -> o_wb_data 0xFFFF_FF80.
REQ-023 Half, unsigned: LHU with addr 0x1002 and rdata 0x8001_1234 -> o_wb_data 0x0000_8001; LH with the same inputs -> 0xFFFF_8001.
REQ-024 Misaligned: LW with addr 0x1001 -> o_misalign pulses once, o_mem_valid stays 0, and o_req_ready is high in the following cycle.
REQ-025 Backpressure:
- i_mem_ready held low for 4 cycles -> o_mem_valid and addr 0x1000 stay stable.
- i_wb_ready low for 3 cycles -> o_wb_valid and data stay stable.
REQ-026 Reset in WAIT, followed by rvalid one cycle later -> no o_wb_valid, and the FSM is in IDLE.
REQ-027 With LOAD_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, with no rvalid -> o_err pulses after 4 WAIT cycles and there is no writeback.

Source files
------------

// File: rtl/load_pkg.sv
// load_pkg: shared FSM state encoding, load size codes and alignment helper
// for the load_extend_ctrl slice.
package load_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Load size codes as presented on i_req_size; 2'b11 behaves as a word
    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_WORD_X = 2'b11
    } size_t;

    // Half accesses need addr[0]==0, word accesses need addr[1:0]==0
    function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_lane_ext.sv
// load_lane_ext: little-endian lane select of a 32-bit read word followed by
// sign or zero extension to the full writeback width.
module load_lane_ext
    import load_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            addr_lo,
    input  size_t                 size,
    input  logic                  is_signed,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane and fill the upper bits with signed & lane MSB
    always_comb begin
        byte_lane = '0;
        half_lane = '0;
        data      = '0;
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{(DATA_WIDTH-8){is_signed & byte_lane[7]}}, byte_lane};
            SZ_HALF: data = {{(DATA_WIDTH-16){is_signed & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_extend_ctrl.sv
// load_extend_ctrl: single-outstanding load controller. Accepts a load,
// checks alignment, issues a word-aligned memory read, extends the returned
// lane and hands it to writeback.
// Optional feature: define LOAD_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles (o_err pulses on expiry); otherwise WAIT is unbounded.
module load_extend_ctrl
    import load_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_signed,
    input  logic [4:0]            i_req_rd,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_wb_valid,
    input  logic                  i_wb_ready,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic [4:0]            o_wb_rd,
    output logic                  o_misalign,
    output logic                  o_err,
    output logic                  o_busy
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("load_extend_ctrl supports DATA_WIDTH == 32 only");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("load_extend_ctrl needs TIMEOUT_CYCLES >= 1");
    end

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    size_t                   size_q;
    logic                    sgn_q;
    logic [4:0]              rd_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;
    logic [DATA_WIDTH-1:0]   ext_data;
    logic                    misalign_q;
    logic                    accept;
    logic                    req_mis;
    logic                    timeout_hit;

    assign accept  = i_req_valid && (state_q == IDLE);
    assign req_mis = is_misaligned(size_t'(i_req_size), i_req_addr[1:0]);

    load_lane_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_ext (
        .rdata     (i_mem_rdata),
        .addr_lo   (addr_q[1:0]),
        .size      (size_q),
        .is_signed (sgn_q),
        .data      (ext_data)
    );

`ifdef LOAD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Expiry is detected in the last allowed WAIT cycle so IDLE follows
    // exactly TIMEOUT_CYCLES WAIT cycles.
    assign timeout_hit = (state_q == WAIT) && !i_mem_rvalid &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_err       = err_q;

    // WAIT cycle counter, cleared on entry to WAIT; one-cycle error pulse
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state_q == REQ && i_mem_ready)
                cnt_q <= '0;
            else if (state_q == WAIT)
                cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

    // State register
    always_ff @(posedge i_CLK) begin
        if (i_RST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; misaligned accepts stay in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !req_mis) state_d = REQ;
            REQ:  if (i_mem_ready)        state_d = WAIT;
            WAIT: begin
                if (i_mem_rvalid)         state_d = RESP;
                else if (timeout_hit)     state_d = IDLE;
            end
            RESP: if (i_wb_ready)         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        o_req_ready = (state_q == IDLE);
        o_mem_valid = (state_q == REQ);
        o_wb_valid  = (state_q == RESP);
        o_busy      = (state_q != IDLE);
    end

    // Request capture, misalign pulse and extended-result capture
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            sgn_q      <= 1'b0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && req_mis;
            if (accept) begin
                addr_q <= i_req_addr;
                size_q <= size_t'(i_req_size);
                sgn_q  <= i_req_signed;
                rd_q   <= i_req_rd;
            end
            if (state_q == WAIT && i_mem_rvalid)
                wb_data_q <= (rd_q == 5'd0) ? '0 : ext_data;
        end
    end

    assign o_mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign o_wb_data  = wb_data_q;
    assign o_wb_rd    = rd_q;
    assign o_misalign = misalign_q;

endmodule

// File: tb/tb_load_extend_ctrl.sv
// tb_load_extend_ctrl: directed-vector bench with a writeback scoreboard.
// Build with +define+LOAD_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_load_extend_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        misalign;
    logic        err;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    logic [36:0] exp_q[$];   // {rd, data}

    always #5 clk = ~clk;

    load_extend_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_size   (req_size),
        .i_req_signed (req_signed),
        .i_req_rd     (req_rd),
        .o_mem_valid  (mem_valid),
        .i_mem_ready  (mem_ready),
        .o_mem_addr   (mem_addr),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_wb_valid   (wb_valid),
        .i_wb_ready   (wb_ready),
        .o_wb_data    (wb_data),
        .o_wb_rd      (wb_rd),
        .o_misalign   (misalign),
        .o_err        (err),
        .o_busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted writeback is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wb_data", wb_data, e[31:0]);
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
            end
        end
    end

    task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                            input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp_data,
                            input int mem_stall, input int wb_stall);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        exp_q.push_back({rd, exp_data});
        req_valid = 1'b1; req_addr = addr; req_size = size; req_signed = sgn; req_rd = rd;
        tick();
        req_valid = 1'b0;
        check("mem_valid_after_accept", {31'd0, mem_valid}, 32'd1);
        check("mem_addr", mem_addr, waddr);
        // rvalid outside WAIT must be ignored
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        for (int i = 0; i < mem_stall; i++) begin
            tick();
            check("mem_valid_stall", {31'd0, mem_valid}, 32'd1);
            check("mem_addr_stall", mem_addr, waddr);
        end
        mem_rvalid = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("mem_valid_drop", {31'd0, mem_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        check("wb_valid_latency", {31'd0, wb_valid}, 32'd1);
        wb_ready = 1'b0;
        for (int i = 0; i < wb_stall; i++) begin
            tick();
            check("wb_valid_stall", {31'd0, wb_valid}, 32'd1);
            check("wb_data_stall", wb_data, exp_data);
        end
        wb_ready = 1'b1;
        check("req_ready_in_wb_hs", {31'd0, req_ready}, 32'd0);
        tick();
        wb_ready = 1'b0;
        check("req_ready_after_wb", {31'd0, req_ready}, 32'd1);
        check("busy_after_wb", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0;
        req_rd = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
        tick(); tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_outputs", {26'd0, mem_valid, wb_valid, misalign, err, busy, 1'b0}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        rst = 1'b0;
        tick();

        // addr, size, signed, rd, rdata, expected, mem stall, wb stall
        run_load(32'h1003, 2'b00, 1'b1, 5'd5,  32'h80FF_FF7F, 32'hFFFF_FF80, 0, 0);
        run_load(32'h1002, 2'b01, 1'b0, 5'd6,  32'h8001_1234, 32'h0000_8001, 0, 0);
        run_load(32'h1002, 2'b01, 1'b1, 5'd7,  32'h8001_1234, 32'hFFFF_8001, 0, 0);
        run_load(32'h1000, 2'b10, 1'b1, 5'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 4, 3);
        run_load(32'h1001, 2'b00, 1'b0, 5'd9,  32'h80FF_FF7F, 32'h0000_00FF, 1, 0);
        run_load(32'h1000, 2'b00, 1'b1, 5'd10, 32'h80FF_FF7F, 32'h0000_007F, 0, 1);
        run_load(32'h2000, 2'b10, 1'b0, 5'd0,  32'h1234_5678, 32'h0000_0000, 0, 0);
        run_load(32'h3004, 2'b11, 1'b1, 5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 0);
        run_load(32'h1000, 2'b01, 1'b1, 5'd12, 32'h8001_1234, 32'h0000_1234, 0, 0);

        // Misaligned word and half: single pulse, no memory access
        for (int k = 0; k < 2; k++) begin
            req_valid = 1'b1; req_addr = (k == 0) ? 32'h1001 : 32'h1003;
            req_size = (k == 0) ? 2'b10 : 2'b01; req_signed = 1'b0; req_rd = 5'd3;
            tick();
            req_valid = 1'b0;
            check("misalign_pulse", {31'd0, misalign}, 32'd1);
            check("misalign_no_mem", {31'd0, mem_valid}, 32'd0);
            check("misalign_req_ready", {31'd0, req_ready}, 32'd1);
            tick();
            check("misalign_single", {31'd0, misalign}, 32'd0);
            check("misalign_no_mem2", {31'd0, mem_valid}, 32'd0);
        end

        // Reset while in WAIT, then a late rvalid
        req_valid = 1'b1; req_addr = 32'h1000; req_size = 2'b10; req_rd = 5'd4;
        tick();
        req_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("wait_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_idle", {31'd0, req_ready}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        check("late_rvalid_no_wb", {31'd0, wb_valid}, 32'd0);
        check("late_rvalid_idle", {31'd0, busy}, 32'd0);
        tick();
        check("late_rvalid_no_wb2", {31'd0, wb_valid}, 32'd0);

`ifdef LOAD_TIMEOUT_EN
        req_valid = 1'b1; req_addr = 32'h1000; req_size = 2'b10; req_rd = 5'd2;
        tick();
        req_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_err_low", {31'd0, err}, 32'd0);
            check("to_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        check("to_err_pulse", {31'd0, err}, 32'd1);
        check("to_no_wb", {31'd0, wb_valid}, 32'd0);
        check("to_idle", {31'd0, req_ready}, 32'd1);
        tick();
        check("to_err_single", {31'd0, err}, 32'd0);
`else
        // Long WAIT without rvalid: no error, still waiting
        req_valid = 1'b1; req_addr = 32'h1004; req_size = 2'b10; req_rd = 5'd2;
        exp_q.push_back({5'd2, 32'h0BAD_F00D});
        tick();
        req_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("no_timeout_err", {31'd0, err}, 32'd0);
        check("no_timeout_busy", {31'd0, busy}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_rvalid = 1'b0; wb_ready = 1'b1;
        check("no_timeout_wb", {31'd0, wb_valid}, 32'd1);
        tick();
        wb_ready = 1'b0;
`endif

        tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
